// File: rtl/demux2_reg.sv
// 1-to-2 registered demultiplexer: each output port owns a single holding
// register with ready/valid handshake and a wrapping delivery counter.

module demux2_reg_port #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [15:0]      cnt,
    output logic             free
);
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             deliver;

    always_comb begin
        deliver = valid_q && ready;
        free    = !valid_q || ready;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        // a load wins over a drain so a same-cycle drain+load leaves no bubble
        if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
        end else if (deliver) begin
            valid_d = 1'b0;
        end
        if (deliver) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign cnt   = cnt_q;
endmodule

module demux2_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    output logic             in_ready,
    output logic             a_valid,
    output logic [WIDTH-1:0] a_data,
    input  logic             a_ready,
    output logic             b_valid,
    output logic [WIDTH-1:0] b_data,
    input  logic             b_ready,
    output logic [15:0]      cnt_a,
    output logic [15:0]      cnt_b
);
    localparam int NUM_PORTS = 2;

    logic [NUM_PORTS-1:0]            port_free;
    logic [NUM_PORTS-1:0]            port_load;
    logic [NUM_PORTS-1:0]            port_ready;
    logic [NUM_PORTS-1:0]            port_valid;
    logic [NUM_PORTS-1:0][WIDTH-1:0] port_data;
    logic [NUM_PORTS-1:0][15:0]      port_cnt;
    logic                            accept;

    assign port_ready = {b_ready, a_ready};
    // ready only looks at the selected port, so a stalled peer never blocks
    assign in_ready   = port_free[in_sel];
    assign accept     = in_valid && in_ready;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        localparam logic SEL = (g == 1);
        assign port_load[g] = accept && (in_sel == SEL);

        demux2_reg_port #(.WIDTH(WIDTH)) u_port (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (port_load[g]),
            .ready   (port_ready[g]),
            .in_data (in_data),
            .valid   (port_valid[g]),
            .data    (port_data[g]),
            .cnt     (port_cnt[g]),
            .free    (port_free[g])
        );
    end

    assign a_valid = port_valid[0];
    assign a_data  = port_data[0];
    assign cnt_a   = port_cnt[0];
    assign b_valid = port_valid[1];
    assign b_data  = port_data[1];
    assign cnt_b   = port_cnt[1];
endmodule
